// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types for the 5-stage pipeline hazard controller.
//   REG_ADDR_W  - register-address width
//   fwd_sel_t   - E-stage ALU operand source select
//   stage_tag_t - per-stage tracking tag {valid, regwrite, rd}
//   tagHits()   - true when a stage will write the given source register
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic [REG_ADDR_W-1:0] rd;
  } stage_tag_t;

  // x0 is hard-wired to zero, so a write to it never produces a value worth
  // forwarding.
  function automatic logic tagHits(input stage_tag_t tag,
                                   input logic [REG_ADDR_W-1:0] rs);
    return tag.valid & tag.regwrite & (tag.rd != '0) & (tag.rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: datapath <-> hazard controller signal bundle.
//   master: datapath side (drives D/E/M instruction info, receives controls)
//   slave : controller side (pipeline_ctrl)
// Inputs : rs1_d, rs2_d, rd_d, regwrite_d, load_d, pcsrc_e, mem_req_m,
//          mem_ready_m
// Outputs: stall_f, stall_d, flush_d, flush_e, stall_em, bubble_w,
//          fwd_a_e, fwd_b_e, valid_w
//
// Handshake: the data-memory access of the M instruction is a req/ready
// pair. It completes on the first cycle with mem_req_m & mem_ready_m both
// high; every cycle with mem_req_m high and mem_ready_m low holds the whole
// pipe (F..M frozen, W gets a bubble). mem_req_m must stay high and the M
// instruction unchanged until completion.
interface pipeline_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] rs1_d;
  logic [REG_ADDR_W-1:0] rs2_d;
  logic [REG_ADDR_W-1:0] rd_d;
  logic                  regwrite_d;
  logic                  load_d;
  logic                  pcsrc_e;
  logic                  mem_req_m;
  logic                  mem_ready_m;

  logic                  stall_f;
  logic                  stall_d;
  logic                  flush_d;
  logic                  flush_e;
  logic                  stall_em;
  logic                  bubble_w;
  logic [1:0]            fwd_a_e;
  logic [1:0]            fwd_b_e;
  logic                  valid_w;

  modport master (
    output rs1_d, rs2_d, rd_d, regwrite_d, load_d, pcsrc_e, mem_req_m,
           mem_ready_m,
    input  stall_f, stall_d, flush_d, flush_e, stall_em, bubble_w,
           fwd_a_e, fwd_b_e, valid_w
  );

  modport slave (
    input  rs1_d, rs2_d, rd_d, regwrite_d, load_d, pcsrc_e, mem_req_m,
           mem_ready_m,
    output stall_f, stall_d, flush_d, flush_e, stall_em, bubble_w,
           fwd_a_e, fwd_b_e, valid_w
  );
endinterface

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: forwarding select for one E-stage source operand.
//   rsE    - source register of the instruction in E
//   tagM   - tag of the instruction in M
//   tagW   - tag of the instruction in W
//   fwdSel - FWD_M if M produces rsE, else FWD_W if W does, else FWD_RF
// M wins over W because it holds the younger (more recent) write.
module hazard_fwd_sel
  import pipeline_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rsE,
  input  stage_tag_t            tagM,
  input  stage_tag_t            tagW,
  output fwd_sel_t              fwdSel
);

  always_comb begin
    fwdSel = FWD_RF;
    if (tagHits(tagM, rsE)) begin
      fwdSel = FWD_M;
    end else if (tagHits(tagW, rsE)) begin
      fwdSel = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for a 5-stage RISC-V
// pipeline (F/D/E/M/W).
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - pipeline_ctrl_if.slave: D/E/M instruction info in, pipeline
//          register enables/flushes, forwarding selects and valid_w out
// Optional build macro PIPELINE_CTRL_PERF_EN adds perf_cycles, perf_stalls
// and perf_flushes (DATA_WIDTH bits each, wrapping, cleared by rst).
//
// Priority of pipeline events: mem_stall > redirect > load_use.
//   mem_stall: freeze F..M, bubble into W, hold off flushes and load-use.
//   redirect : flush D and E (two bubbles); the D instruction is wrong-path,
//              so any load-use it would cause is ignored.
//   load_use : hold F and D one cycle, bubble into E.
// All outputs are combinational and forced low while rst is high.
module pipeline_ctrl #(
  parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_ctrl_if.slave        bus
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [DATA_WIDTH-1:0] perf_cycles,
  output logic [DATA_WIDTH-1:0] perf_stalls,
  output logic [DATA_WIDTH-1:0] perf_flushes
`endif
);

  import pipeline_pkg::*;

  // Stage tags are sized by the package; reject a mismatched override.
  if (DATA_WIDTH < 1 || REG_ADDR_W != pipeline_pkg::REG_ADDR_W) begin : gBadParams
    $error("pipeline_ctrl: unsupported parameter values");
  end

  logic                  validD;
  stage_tag_t            tagE;
  stage_tag_t            tagM;
  stage_tag_t            tagW;
  logic                  loadE;
  logic [REG_ADDR_W-1:0] rs1E;
  logic [REG_ADDR_W-1:0] rs2E;

  logic                  memStall;
  logic                  redirect;
  logic                  loadUse;
  logic                  stallFD;
  logic                  flushE;
  stage_tag_t            tagD;
  fwd_sel_t              fwdA;
  fwd_sel_t              fwdB;

  assign memStall = tagM.valid & bus.mem_req_m & ~bus.mem_ready_m;
  assign redirect = tagE.valid & bus.pcsrc_e & ~memStall;
  assign loadUse  = tagE.valid & loadE & (tagE.rd != '0)
                  & ((tagE.rd == bus.rs1_d) | (tagE.rd == bus.rs2_d))
                  & validD & ~redirect & ~memStall;

  assign stallFD  = memStall | loadUse;
  assign flushE   = redirect | loadUse;
  assign tagD     = '{valid: validD, regwrite: bus.regwrite_d, rd: bus.rd_d};

  hazard_fwd_sel uFwdA (
    .rsE    (rs1E),
    .tagM   (tagM),
    .tagW   (tagW),
    .fwdSel (fwdA)
  );

  hazard_fwd_sel uFwdB (
    .rsE    (rs2E),
    .tagM   (tagM),
    .tagW   (tagW),
    .fwdSel (fwdB)
  );

  assign bus.stall_f  = ~rst & stallFD;
  assign bus.stall_d  = ~rst & stallFD;
  assign bus.flush_d  = ~rst & redirect;
  assign bus.flush_e  = ~rst & flushE;
  assign bus.stall_em = ~rst & memStall;
  assign bus.bubble_w = ~rst & memStall;
  assign bus.valid_w  = ~rst & tagW.valid;
  assign bus.fwd_a_e  = rst ? FWD_RF : fwdA;
  assign bus.fwd_b_e  = rst ? FWD_RF : fwdB;

  always_ff @(posedge clk) begin
    if (rst) begin
      validD <= 1'b0;
      tagE   <= '0;
      tagM   <= '0;
      tagW   <= '0;
      loadE  <= 1'b0;
      rs1E   <= '0;
      rs2E   <= '0;
    end else begin
      // D: killed by a redirect, held while F/D is stalled, otherwise the
      // fetched instruction is real.
      if (redirect) begin
        validD <= 1'b0;
      end else if (!stallFD) begin
        validD <= 1'b1;
      end

      if (!memStall) begin
        // Source tags are loaded even for a bubble; only valid/regwrite
        // matter in a bubble.
        rs1E <= bus.rs1_d;
        rs2E <= bus.rs2_d;
        if (flushE) begin
          tagE  <= '{valid: 1'b0, regwrite: 1'b0, rd: bus.rd_d};
          loadE <= 1'b0;
        end else begin
          tagE  <= tagD;
          loadE <= bus.load_d;
        end
        tagM <= tagE;
        tagW <= tagM;
      end else begin
        tagW <= '0;
      end
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles  <= '0;
      perf_stalls  <= '0;
      perf_flushes <= '0;
    end else begin
      perf_cycles <= perf_cycles + DATA_WIDTH'(1);
      if (stallFD) begin
        perf_stalls <= perf_stalls + DATA_WIDTH'(1);
      end
      if (redirect) begin
        perf_flushes <= perf_flushes + DATA_WIDTH'(1);
      end
    end
  end
`endif

endmodule
